// File: rtl/mem_pkg.sv
// Shared types and constants for the memory responder.
package mem_pkg;

    // Responder FSM states.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        A_RD = 3'd1,
        A_WS = 3'd2,
        A_WP = 3'd3,
        A_WH = 3'd4,
        B_RD = 3'd5,
        DONE = 3'd6
    } memState_t;

    // Port A command encodings; 2'b11 is treated as no request.
    localparam logic [1:0] RW_NONE  = 2'b00;
    localparam logic [1:0] RW_READ  = 2'b01;
    localparam logic [1:0] RW_WRITE = 2'b10;

    localparam int DEFAULT_WAIT_CYCLES = 1;

    // Wait counter width, large enough for WAIT_CYCLES up to 15.
    localparam int CNT_W = 4;

endpackage

// File: rtl/mem_wait_counter.sv
// Loadable down-counter that times the OE-low and WE-low windows.
// 'terminal' is high while the count is zero, i.e. during the last cycle of a window.
module mem_wait_counter
    import mem_pkg::*;
#(
    parameter int CW = CNT_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [CW-1:0] loadVal,
    output logic          terminal
);

    logic [CW-1:0] count;

    // Load takes priority; otherwise count down and park at zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= loadVal;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign terminal = (count == '0);

endmodule

// File: rtl/mem_responder.sv
// Serialises CPU port A (load/store) and port B (fetch) onto one asynchronous
// single-port SRAM. Every SRAM control/address/data output is a flop, decoded
// from the next state so it lines up with the state it belongs to.
//
// Handshake: the CPU presents a request (rw and/or fetchEn) and must hold all
// request inputs while stall is high. Requests are latched on leaving IDLE.
// The single DONE cycle has stall low, which lets the CPU advance exactly once.
module mem_responder
    import mem_pkg::*;
#(
    parameter int WAIT_CYCLES = DEFAULT_WAIT_CYCLES,
    parameter int SRAM_AW     = 18
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [15:0]        Aaddr,
    input  logic [15:0]        dataWrtie,
    input  logic [1:0]         rw,
    input  logic [15:0]        Baddr,
    input  logic               fetchEn,
    output logic [15:0]        AmemRead,
    output logic [15:0]        BmemRead,
    output logic               stall,
    output logic [SRAM_AW-1:0] sramAddr,
    output logic [15:0]        sramDout,
    output logic               sramDoutEn,
    input  logic [15:0]        sramDin,
    output logic               sramCE_n,
    output logic               sramOE_n,
    output logic               sramWE_n,
    output memState_t          dbgState
);

    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES - 1);

    memState_t   state;
    memState_t   nextState;
    logic        cntLoad;
    logic        cntDone;
    logic        pendB;
    logic [15:0] bAddrQ;
    logic        reqA;
    logic        reqB;

    assign reqA     = (rw == RW_READ) || (rw == RW_WRITE);
    assign reqB     = fetchEn;
    assign dbgState = state;

    mem_wait_counter #(.CW(CNT_W)) waitCnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cntLoad),
        .loadVal  (WAIT_LOAD),
        .terminal (cntDone)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state decode; A write beats A read beats B fetch.
    always_comb begin
        nextState = state;
        cntLoad   = 1'b0;
        unique case (state)
            IDLE: begin
                if (rw == RW_WRITE) begin
                    nextState = A_WS;
                end else if (rw == RW_READ) begin
                    nextState = A_RD;
                    cntLoad   = 1'b1;
                end else if (reqB) begin
                    nextState = B_RD;
                    cntLoad   = 1'b1;
                end
            end
            A_RD: begin
                if (cntDone) begin
                    if (pendB) begin
                        nextState = B_RD;
                        cntLoad   = 1'b1;
                    end else begin
                        nextState = DONE;
                    end
                end
            end
            A_WS: begin
                nextState = A_WP;
                cntLoad   = 1'b1;
            end
            A_WP: begin
                if (cntDone) nextState = A_WH;
            end
            A_WH: begin
                if (pendB) begin
                    nextState = B_RD;
                    cntLoad   = 1'b1;
                end else begin
                    nextState = DONE;
                end
            end
            B_RD: begin
                if (cntDone) nextState = DONE;
            end
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Combinational stall: a fresh request in IDLE stalls immediately.
    always_comb begin
        stall = 1'b0;
        if (state == IDLE) begin
            stall = reqA || reqB;
        end else if (state != DONE) begin
            stall = 1'b1;
        end
    end

    // Latch the port B request while idle; port A is consumed straight from the inputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pendB  <= 1'b0;
            bAddrQ <= '0;
        end else if (state == IDLE) begin
            pendB  <= reqB;
            bAddrQ <= Baddr;
        end
    end

    // Registered SRAM pins and read-data capture. Address/data only change when
    // entering a new access, so they are steady around the WE-low window.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sramCE_n   <= 1'b1;
            sramOE_n   <= 1'b1;
            sramWE_n   <= 1'b1;
            sramDoutEn <= 1'b0;
            sramAddr   <= '0;
            sramDout   <= '0;
            AmemRead   <= '0;
            BmemRead   <= '0;
        end else begin
            sramCE_n   <= !(nextState inside {A_RD, B_RD, A_WS, A_WP, A_WH});
            sramOE_n   <= !(nextState inside {A_RD, B_RD});
            sramWE_n   <= !(nextState == A_WP);
            sramDoutEn <= (nextState inside {A_WS, A_WP, A_WH});
            if (state == IDLE && (nextState == A_RD || nextState == A_WS)) begin
                sramAddr <= SRAM_AW'(Aaddr);
            end else if (nextState == B_RD && state != B_RD) begin
                sramAddr <= (state == IDLE) ? SRAM_AW'(Baddr) : SRAM_AW'(bAddrQ);
            end
            if (state == IDLE && nextState == A_WS) begin
                sramDout <= dataWrtie;
            end
            if (state == A_RD && cntDone) begin
                AmemRead <= sramDin;
            end
            if (state == B_RD && cntDone) begin
                BmemRead <= sramDin;
            end
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: SRAM behavioural model, request driver, expected-data
// queues per port, and one summary line.
module tb_mem_responder;
    import mem_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT with WAIT_CYCLES=1 ----------------
    logic [15:0] Aaddr, dataWrtie, Baddr, AmemRead, BmemRead, sramDout, sramDin;
    logic [1:0]  rw;
    logic        fetchEn, stall, sramDoutEn, sramCE_n, sramOE_n, sramWE_n;
    logic [17:0] sramAddr;
    memState_t   dbgState;

    mem_responder #(.WAIT_CYCLES(1), .SRAM_AW(18)) dut (
        .clk(clk), .rst(rst), .Aaddr(Aaddr), .dataWrtie(dataWrtie), .rw(rw),
        .Baddr(Baddr), .fetchEn(fetchEn), .AmemRead(AmemRead), .BmemRead(BmemRead),
        .stall(stall), .sramAddr(sramAddr), .sramDout(sramDout), .sramDoutEn(sramDoutEn),
        .sramDin(sramDin), .sramCE_n(sramCE_n), .sramOE_n(sramOE_n), .sramWE_n(sramWE_n),
        .dbgState(dbgState)
    );

    // SRAM model: combinational read, write sampled mid-cycle while WE is low.
    logic [15:0] mem [0:65535];
    assign sramDin = (!sramCE_n && !sramOE_n) ? mem[sramAddr[15:0]] : 16'h0000;
    always @(negedge clk) begin
        if (!sramCE_n && !sramWE_n) mem[sramAddr[15:0]] = sramDout;
    end

    // ---------------- DUT with WAIT_CYCLES=3 ----------------
    logic [15:0] aAddr3, data3, bAddr3, aRead3, bRead3, sramDout3, sramDin3;
    logic [1:0]  rw3;
    logic        fetch3, stall3, doutEn3, ce3N, oe3N, we3N;
    logic [17:0] sramAddr3;
    memState_t   dbgState3;

    mem_responder #(.WAIT_CYCLES(3), .SRAM_AW(18)) dut3 (
        .clk(clk), .rst(rst), .Aaddr(aAddr3), .dataWrtie(data3), .rw(rw3),
        .Baddr(bAddr3), .fetchEn(fetch3), .AmemRead(aRead3), .BmemRead(bRead3),
        .stall(stall3), .sramAddr(sramAddr3), .sramDout(sramDout3), .sramDoutEn(doutEn3),
        .sramDin(sramDin3), .sramCE_n(ce3N), .sramOE_n(oe3N), .sramWE_n(we3N),
        .dbgState(dbgState3)
    );

    assign sramDin3 = (!ce3N && !oe3N) ? (sramAddr3[15:0] ^ 16'hA5A5) : 16'h0000;

    // ---------------- scoreboard ----------------
    logic [15:0] expAQ[$];
    logic [15:0] expBQ[$];
    int errors = 0;
    int checks = 0;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic popA();
        if (expAQ.size() == 0) checkVal("a_queue_empty", 1, 0);
        else checkVal("a_read_data", AmemRead, expAQ.pop_front());
    endtask

    task automatic popB();
        if (expBQ.size() == 0) checkVal("b_queue_empty", 1, 0);
        else checkVal("b_read_data", BmemRead, expBQ.pop_front());
    endtask

    // ---------------- driver ----------------
    // Called just after a falling edge. Holds the request while stall is high,
    // counting stall/OE/WE/drive cycles; returns just after the edge following DONE.
    task automatic runReq(input logic [1:0] rwV, input logic [15:0] aA, input logic [15:0] d,
                          input logic fe, input logic [15:0] bA,
                          output int stallCyc, output int oeCyc, output int weCyc,
                          output int enCyc, output int badWin);
        rw = rwV; Aaddr = aA; dataWrtie = d; fetchEn = fe; Baddr = bA;
        stallCyc = 0; oeCyc = 0; weCyc = 0; enCyc = 0; badWin = 0;
        #1;
        for (int i = 0; i < 40 && stall; i++) begin
            stallCyc++;
            if (!sramOE_n) oeCyc++;
            if (!sramWE_n) weCyc++;
            if (sramDoutEn) begin
                enCyc++;
                if (sramAddr != {2'b00, aA} || sramDout != d || !sramOE_n) badWin++;
            end
            @(negedge clk); #1;
        end
        checkVal("stall_released", stall, 0);
        checkVal("done_state", dbgState, DONE);
        rw = RW_NONE; fetchEn = 1'b0;
        @(negedge clk); #1;
        checkVal("idle_after_done", dbgState, IDLE);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int sc, oc, wc, ec, bw;
        logic [15:0] a, b;

        rw = RW_NONE; Aaddr = 0; dataWrtie = 0; Baddr = 0; fetchEn = 0;
        rw3 = RW_NONE; aAddr3 = 0; data3 = 0; bAddr3 = 0; fetch3 = 0;
        mem[16'h0010] = 16'h1234;
        mem[16'h8000] = 16'hBEEF;
        mem[16'h0011] = 16'hCAFE;
        mem[16'h0012] = 16'h7777;
        mem[16'h0200] = 16'h0000;

        // Reset values
        #12;
        checkVal("rst_ce", sramCE_n, 1);
        checkVal("rst_oe", sramOE_n, 1);
        checkVal("rst_we", sramWE_n, 1);
        checkVal("rst_douten", sramDoutEn, 0);
        checkVal("rst_addr", sramAddr, 0);
        checkVal("rst_amem", AmemRead, 0);
        checkVal("rst_bmem", BmemRead, 0);
        checkVal("rst_state", dbgState, IDLE);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); #1;
        checkVal("idle_no_stall", stall, 0);

        // Fetch only
        expBQ.push_back(16'h1234);
        runReq(RW_NONE, 16'h0000, 16'h0000, 1'b1, 16'h0010, sc, oc, wc, ec, bw);
        checkVal("fetch_stall_cycles", sc, 2);
        checkVal("fetch_oe_cycles", oc, 1);
        popB();

        // Load + fetch: A first, then B
        expAQ.push_back(16'hBEEF);
        expBQ.push_back(16'hCAFE);
        runReq(RW_READ, 16'h8000, 16'h0000, 1'b1, 16'h0011, sc, oc, wc, ec, bw);
        checkVal("load_fetch_stall_cycles", sc, 3);
        checkVal("load_fetch_oe_cycles", oc, 2);
        popA();
        popB();

        // Port A data must hold across a fetch-only request
        expAQ.push_back(16'hBEEF);
        expBQ.push_back(16'h1234);
        runReq(RW_NONE, 16'h0000, 16'h0000, 1'b1, 16'h0010, sc, oc, wc, ec, bw);
        popA();
        popB();

        // Store + fetch
        expBQ.push_back(16'h7777);
        runReq(RW_WRITE, 16'h0200, 16'h5A5A, 1'b1, 16'h0012, sc, oc, wc, ec, bw);
        checkVal("store_stall_cycles", sc, 5);
        checkVal("store_we_cycles", wc, 1);
        checkVal("store_drive_cycles", ec, 3);
        checkVal("store_window_stable", bw, 0);
        checkVal("store_oe_cycles", oc, 1);
        checkVal("store_mem", mem[16'h0200], 16'h5A5A);
        popB();

        // Random load + fetch pairs
        for (int k = 0; k < 4; k++) begin
            a = 16'h0100 + 16'($urandom_range(0, 255));
            b = 16'h0400 + 16'($urandom_range(0, 255));
            mem[a] = 16'($urandom);
            mem[b] = 16'($urandom);
            expAQ.push_back(mem[a]);
            expBQ.push_back(mem[b]);
            runReq(RW_READ, a, 16'h0000, 1'b1, b, sc, oc, wc, ec, bw);
            checkVal("rand_stall_cycles", sc, 3);
            popA();
            popB();
        end

        // rw=11 without fetch is no request
        rw = 2'b11; Aaddr = 16'h0044; fetchEn = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            checkVal("rw11_stall", stall, 0);
            checkVal("rw11_ce", sramCE_n, 1);
            checkVal("rw11_state", dbgState, IDLE);
            @(negedge clk);
        end
        rw = RW_NONE;

        // Reset while WE is low
        @(negedge clk);
        rw = RW_WRITE; Aaddr = 16'h0300; dataWrtie = 16'h1111; fetchEn = 1'b0;
        for (int k = 0; k < 10 && sramWE_n; k++) @(negedge clk);
        checkVal("we_low_reached", sramWE_n, 0);
        #2 rst = 1'b0;
        #1;
        checkVal("async_we", sramWE_n, 1);
        checkVal("async_oe", sramOE_n, 1);
        checkVal("async_ce", sramCE_n, 1);
        checkVal("async_douten", sramDoutEn, 0);
        rw = RW_NONE;
        @(negedge clk); rst = 1'b1;
        #1;
        checkVal("post_rst_amem", AmemRead, 0);
        checkVal("post_rst_stall", stall, 0);
        checkVal("post_rst_state", dbgState, IDLE);

        // WAIT_CYCLES=3 instance: single A read
        @(negedge clk);
        rw3 = RW_READ; aAddr3 = 16'h0033;
        sc = 0; oc = 0;
        #1;
        for (int i = 0; i < 40 && stall3; i++) begin
            sc++;
            if (!oe3N) oc++;
            @(negedge clk); #1;
        end
        rw3 = RW_NONE;
        checkVal("w3_stall_cycles", sc, 4);
        checkVal("w3_oe_cycles", oc, 3);
        checkVal("w3_read_data", aRead3, 16'h0033 ^ 16'hA5A5);
        checkVal("w3_done_state", dbgState3, DONE);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the CPU's two memory ports: port A (data load/store, driven by Aaddr/dataWrtie/rw) and port B (instruction fetch, driven by Baddr).
- Serialises both ports onto one external single-port asynchronous SRAM and returns read data on AmemRead/BmemRead.
- Raises stall so the CPU pipeline holds its request signals until every pending access is serviced.
- Sits between cpu and the board SRAM pins; the tri-state buffer lives in the top level.

Parameters:
- WAIT_CYCLES, 1, SRAM access cycles per read (OE low) or write (WE low); legal range 1..15.
- SRAM_AW, 18, SRAM address width; the 16-bit CPU address is zero-extended.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- Aaddr  in  16  port A word address
- dataWrtie  in  16  port A store data
- rw  in  2  port A command: 00 none, 01 read, 10 write, 11 illegal (treated as none)
- Baddr  in  16  port B fetch address
- fetchEn  in  1  port B fetch request
- AmemRead  out  16  port A read data, registered
- BmemRead  out  16  port B read data, registered
- stall  out  1  CPU must hold all request inputs while high
- sramAddr  out  SRAM_AW  SRAM address
- sramDout  out  16  SRAM write data
- sramDoutEn  out  1  drive sramDout onto the pad bus
- sramDin  in  16  SRAM pad data
- sramCE_n, sramOE_n, sramWE_n  out  1 each  SRAM strobes, active-low, all registered

Behaviour:
- Reset (rst low, asynchronous): state IDLE, counter 0, AmemRead=0, BmemRead=0, sramAddr=0, sramDout=0, sramDoutEn=0, all strobes 1.
- Reset mid-write deasserts sramWE_n immediately.
- States: IDLE, A_RD, A_WS (write setup), A_WP (write pulse), A_WH (write hold), B_RD, DONE.
- IDLE:
  - Latch pendA = (rw==01 || rw==10), pendB = fetchEn, and the request address/data.
  - Priority: A write -> A_WS, else A read -> A_RD, else B -> B_RD, else stay in IDLE.
- A_RD / B_RD:
  - sramCE_n=0, sramOE_n=0, sramAddr = latched address, for WAIT_CYCLES cycles.
  - On the clock edge ending the last cycle, capture sramDin into AmemRead or BmemRead.
  - After A_RD: go to B_RD if pendB, else DONE. After B_RD: go to DONE.
- Write sequence:
  - A_WS: 1 cycle; address and data driven, sramDoutEn=1, WE high.
  - A_WP: WAIT_CYCLES cycles; WE low.
  - A_WH: 1 cycle; WE high, data still driven.
  - Then B_RD if pendB, else DONE.
  - sramOE_n stays 1 throughout the write; sramDoutEn is 0 in every non-write state.
- DONE: strobes idle, stall=0 for exactly one cycle (the CPU advances), then IDLE.
- stall (combinational) = (state==IDLE && (pendA-qualifying rw || fetchEn)) || state not in {IDLE, DONE}.
  - IDLE with no request: stall=0.
- Latency with WAIT_CYCLES=1, stall-high cycles:
  - B only: 2
  - A read + B: 3
  - A write + B: 5
- AmemRead/BmemRead hold their value until the next capture of the same port.
- rw=11 is ignored as no request. The CPU must not change inputs while stall=1; changes in that window are ignored because requests are latched.
- No strobe glitches: every SRAM control signal is a flop output.
- The WE-low window never overlaps an address or data change.

Decomposition:
- Shared package mem_pkg:
  - state enum
  - rw encodings (RW_NONE, RW_READ, RW_WRITE)
  - default WAIT_CYCLES
- One sub-module, mem_wait_counter: loadable down-counter with a terminal flag, used for the OE/WE timing windows.

Test Plan:
- Reset: hold rst low while sramWE_n is low in A_WP -> WE, OE and CE go to 1 asynchronously; AmemRead=0, stall=0 after release.
- Fetch only: fetchEn=1, Baddr=0x0010, SRAM model returns 0x1234 -> stall high 2 cycles, sramOE_n low 1 cycle, BmemRead=0x1234, DONE lasts 1 cycle.
- Load + fetch: rw=01, Aaddr=0x8000 (model 0xBEEF), Baddr=0x0011 (model 0xCAFE) -> A served first, AmemRead=0xBEEF, BmemRead=0xCAFE, stall high 3 cycles.
- Store + fetch: rw=10, Aaddr=0x0200, dataWrtie=0x5A5A -> model memory[0x0200]=0x5A5A; sramAddr and sramDout stable one cycle before and after the WE-low window; OE never low during the write; then the B read follows.
- WAIT_CYCLES=3: A read -> OE low exactly 3 cycles, stall high 4 cycles (no B request).
- rw=11 with fetchEn=0 -> stall=0, no strobe activity, state remains IDLE.
